// File: rtl/bitstream_packer_fifo_pkg.sv
// Shared types and sizing helpers for the bitstream packer and its output FIFO.
// The package is named packer_pkg because the FSM type is referenced as packer_pkg::pk_state_e.
package packer_pkg;

  typedef enum logic [2:0] {
    RUN,
    STOP,
    PAD,
    DRAIN,
    DONE
  } pk_state_e;

  // The accumulator holds one full output word plus one maximum-width code.
  function automatic int acc_w(input int code_w, input int out_w);
    return code_w + out_w;
  endfunction

  // The fill counter must be able to hold every value from 0 to ACC_W inclusive.
  function automatic int fill_w(input int code_w, input int out_w);
    return $clog2(code_w + out_w + 1);
  endfunction

endpackage

// File: rtl/bitstream_packer_fifo_if.sv
// Code-input and word-output handshakes of the bitstream packer.
// master is the code producer / word consumer side, and slave is the packer.
interface bitstream_packer_fifo_if #(
  parameter int CODE_W = 64,
  parameter int LEN_W  = 7,
  parameter int OUT_W  = 32
);
  logic              code_valid;
  logic              code_ready;
  logic [CODE_W-1:0] codebit;
  logic [LEN_W-1:0]  codelength;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;

  modport master (
    output code_valid, codebit, codelength, out_ready,
    input  code_ready, out_valid, out_data
  );

  modport slave (
    input  code_valid, codebit, codelength, out_ready,
    output code_ready, out_valid, out_data
  );
endinterface

// File: rtl/bitstream_packer_fifo_bs_out_fifo.sv
// Show-ahead output FIFO. Each pointer carries an extra wrap bit, so level is the pointer difference.
// A push that arrives together with a pop is accepted even when the FIFO is full.
module bs_out_fifo #(
  parameter int DEPTH = 64,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_pop, do_push;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; only the pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/bitstream_packer_fifo.sv
// Packs variable-length codes MSB-first into OUT_W-bit words and buffers them in a show-ahead FIFO.
// A flush appends an optional rbsp stop bit, pads with zeros to a word boundary and drains the accumulator.
module bitstream_packer_fifo
  import packer_pkg::*;
#(
  parameter int CODE_W   = 64,
  parameter int LEN_W    = 7,
  parameter int OUT_W    = 32,
  parameter int DEPTH    = 64,
  parameter int STOP_BIT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  bitstream_packer_fifo_if.slave bus,
  input  logic                   flush,
  output logic                   flush_done,
  output logic [$clog2(DEPTH):0] level,
  output logic [31:0]            bit_count
);
  localparam int ACC_W  = acc_w(CODE_W, OUT_W);
  localparam int FILL_W = fill_w(CODE_W, OUT_W);

  pk_state_e         state, state_next;
  logic [ACC_W-1:0]  acc, acc_sh, placed, add_bits;
  logic [FILL_W-1:0] fill, base, add_len, shamt;
  logic [LEN_W-1:0]  len_eff;
  logic              fifo_full, fifo_empty, pop, emit, room, code_ready;

  assign pop  = !fifo_empty && bus.out_ready;
  // A pop in the same cycle frees the slot that the emitted word needs.
  assign emit = (fill >= FILL_W'(OUT_W)) && (!fifo_full || pop);
  assign base = emit ? fill - FILL_W'(OUT_W) : fill;
  assign room = (base < FILL_W'(OUT_W));
  assign acc_sh = emit ? (acc << OUT_W) : acc;

  assign len_eff = (bus.codelength > LEN_W'(CODE_W)) ? LEN_W'(CODE_W) : bus.codelength;

  // New bits are placed directly below the bits that are still held.
  assign shamt  = FILL_W'(ACC_W) - base - add_len;
  assign placed = add_bits << shamt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // NOTE: each combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (flush) state_next = (STOP_BIT != 0) ? STOP : PAD;
      STOP:    if (room) state_next = PAD;
      PAD:     if (room) state_next = DRAIN;
      DRAIN:   if (fill == '0) state_next = DONE;
      DONE:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    code_ready = 1'b0;
    flush_done = 1'b0;
    add_len    = '0;
    add_bits   = '0;
    unique case (state)
      RUN: begin
        code_ready = !flush && room;
        if (code_ready && bus.code_valid) begin
          add_len  = FILL_W'(len_eff);
          add_bits = {{OUT_W{1'b0}}, bus.codebit} & ~({ACC_W{1'b1}} << len_eff);
        end
      end
      STOP: begin
        if (room) begin
          add_len  = FILL_W'(1);
          add_bits = ACC_W'(1);
        end
      end
      PAD: begin
        // Zero bits only advance the fill count; base is zero when the stream is already aligned.
        if (room && base != '0) add_len = FILL_W'(OUT_W) - base;
      end
      DONE:    flush_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      fill      <= '0;
      bit_count <= '0;
    end else begin
      acc       <= acc_sh | placed;
      fill      <= base + add_len;
      bit_count <= bit_count + 32'(add_len);
    end
  end

  assign bus.code_ready = code_ready;
  assign bus.out_valid  = !fifo_empty;

  bs_out_fifo #(
    .DEPTH (DEPTH),
    .W     (OUT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (emit),
    .din   (acc[ACC_W-1 -: OUT_W]),
    .pop   (bus.out_ready),
    .dout  (bus.out_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (level)
  );
endmodule

// File: tb/tb_bitstream_packer_fifo.sv
// Directed bench for bitstream_packer_fifo covering packing, flush, back-pressure, length edge cases and reset.
// Expected words are worked out by hand from the MSB-first concatenation of the codes.
module tb_bitstream_packer_fifo;
  import packer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        flush_done;
  logic [6:0]  level;
  logic [31:0] bit_count;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;

  bitstream_packer_fifo_if #(.CODE_W(64), .LEN_W(7), .OUT_W(32)) bus ();

  bitstream_packer_fifo #(
    .CODE_W(64), .LEN_W(7), .OUT_W(32), .DEPTH(64), .STOP_BIT(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .flush      (flush),
    .flush_done (flush_done),
    .level      (level),
    .bit_count  (bit_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (flush_done) done_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.code_valid = 1'b0;
    bus.codebit    = '0;
    bus.codelength = '0;
    bus.out_ready  = 1'b0;
    flush          = 1'b0;
    rst            = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic send_code(input logic [63:0] c, input logic [6:0] l);
    bit ok = 0;
    bus.code_valid = 1'b1;
    bus.codebit    = c;
    bus.codelength = l;
    for (int n = 0; n < 300 && !ok; n++) begin
      if (bus.code_ready) ok = 1;
      tick();
    end
    bus.code_valid = 1'b0;
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL send_code: code %h len %0d not accepted, required acceptance within 300 cycles", c, l);
    end
  endtask

  task automatic pop_word(output logic [31:0] w, output bit ok);
    ok = 0;
    w  = 'x;
    for (int n = 0; n < 300 && !ok; n++) begin
      if (bus.out_valid) ok = 1;
      else tick();
    end
    if (ok) begin
      w = bus.out_data;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 5;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    if (level !== 7'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", level); end
    if (bus.code_ready !== 1'b1) begin n_bad++; $display("FAIL reset_code_ready: got %b want 1", bus.code_ready); end
    if (flush_done !== 1'b0) begin n_bad++; $display("FAIL reset_flush_done: got %b want 0", flush_done); end
    if (bit_count !== 32'd0) begin n_bad++; $display("FAIL reset_bit_count: got %0d want 0", bit_count); end
  endtask

  // Bits 1 | 101111 | 25 ones -> 1101_1111_1111_... = 0xDFFFFFFF.
  task automatic test_pack();
    logic [31:0] w;
    bit ok;
    do_reset();
    send_code(64'h1, 7'd1);
    send_code(64'h2F, 7'd6);
    send_code(64'h1FF_FFFF, 7'd25);
    n_cmp++;
    if (bit_count !== 32'd32) begin n_bad++; $display("FAIL pack_bit_count: got %0d want 32", bit_count); end
    pop_word(w, ok);
    n_cmp++;
    if (!ok || w !== 32'hDFFF_FFFF) begin n_bad++; $display("FAIL pack_word: got %h (ok=%0d) want dfffffff", w, ok); end
    n_cmp += 2;
    if (level !== 7'd0) begin n_bad++; $display("FAIL pack_level_after_pop: got %0d want 0", level); end
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL pack_out_valid_after_pop: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    logic [31:0] w;
    logic [31:0] exp_w [3] = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h8000_0000};
    bit ok;
    int d0;
    do_reset();
    d0 = done_cnt;
    send_code(64'hDEAD_BEEF_CAFE_F00D, 7'd64);
    pulse_flush();
    repeat (15) tick();
    n_cmp += 4;
    if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL flush_done_pulses: got %0d want 1", done_cnt - d0); end
    if (bit_count !== 32'd96) begin n_bad++; $display("FAIL flush_bit_count: got %0d want 96", bit_count); end
    if (level !== 7'd3) begin n_bad++; $display("FAIL flush_level: got %0d want 3", level); end
    if (bus.code_ready !== 1'b1) begin n_bad++; $display("FAIL flush_back_to_run: code_ready %b want 1", bus.code_ready); end
    for (int i = 0; i < 3; i++) begin
      pop_word(w, ok);
      n_cmp++;
      if (!ok || w !== exp_w[i]) begin n_bad++; $display("FAIL flush_word%0d: got %h (ok=%0d) want %h", i, w, ok, exp_w[i]); end
    end
  endtask

  // 65 words fit: 64 in the FIFO plus one held in the accumulator.
  task automatic test_back_pressure();
    logic [31:0] w;
    bit ok;
    do_reset();
    for (int i = 0; i < 65; i++) send_code(64'(32'hA500_0000 + i), 7'd32);
    repeat (4) tick();
    n_cmp += 3;
    if (level !== 7'd64) begin n_bad++; $display("FAIL bp_level_full: got %0d want 64", level); end
    if (bus.code_ready !== 1'b0) begin n_bad++; $display("FAIL bp_code_ready: got %b want 0", bus.code_ready); end
    if (bus.out_data !== 32'hA500_0000) begin n_bad++; $display("FAIL bp_head: got %h want a5000000", bus.out_data); end

    // Pop and emit coincide while full: occupancy holds at 64.
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    n_cmp += 3;
    if (level !== 7'd64) begin n_bad++; $display("FAIL full_pop_emit_level: got %0d want 64", level); end
    if (bus.out_data !== 32'hA500_0001) begin n_bad++; $display("FAIL full_pop_emit_head: got %h want a5000001", bus.out_data); end
    if (bus.code_ready !== 1'b1) begin n_bad++; $display("FAIL full_pop_emit_ready: got %b want 1", bus.code_ready); end

    for (int i = 1; i < 65; i++) begin
      pop_word(w, ok);
      n_cmp++;
      if (!ok || w !== 32'hA500_0000 + i) begin
        n_bad++;
        $display("FAIL bp_drain_word%0d: got %h (ok=%0d) want %h", i, w, ok, 32'hA500_0000 + i);
      end
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained_empty: out_valid %b want 0", bus.out_valid); end
  endtask

  task automatic test_len_edges();
    logic [31:0] w;
    bit ok;
    do_reset();
    send_code(64'hFFFF_FFFF_FFFF_FFFF, 7'd0);
    repeat (3) tick();
    n_cmp += 2;
    if (bit_count !== 32'd0) begin n_bad++; $display("FAIL len0_bit_count: got %0d want 0", bit_count); end
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL len0_out_valid: got %b want 0", bus.out_valid); end

    send_code(64'h0123_4567_89AB_CDEF, 7'd100);
    repeat (3) tick();
    n_cmp++;
    if (bit_count !== 32'd64) begin n_bad++; $display("FAIL len100_bit_count: got %0d want 64", bit_count); end
    pop_word(w, ok);
    n_cmp++;
    if (!ok || w !== 32'h0123_4567) begin n_bad++; $display("FAIL len100_word0: got %h (ok=%0d) want 01234567", w, ok); end
    pop_word(w, ok);
    n_cmp++;
    if (!ok || w !== 32'h89AB_CDEF) begin n_bad++; $display("FAIL len100_word1: got %h (ok=%0d) want 89abcdef", w, ok); end

    // Bits above codelength are ignored: 0101 followed by 28-bit 0x0000001.
    send_code(64'hFFFF_FFFF_FFFF_FFF5, 7'd4);
    send_code(64'hFFFF_FFFF_F000_0001, 7'd28);
    pop_word(w, ok);
    n_cmp += 2;
    if (!ok || w !== 32'h5000_0001) begin n_bad++; $display("FAIL mask_word: got %h (ok=%0d) want 50000001", w, ok); end
    if (bit_count !== 32'd96) begin n_bad++; $display("FAIL mask_bit_count: got %0d want 96", bit_count); end
  endtask

  task automatic test_reset_mid_flush();
    bit found = 0;
    int d0;
    do_reset();
    send_code(64'h1234_5678, 7'd32);
    send_code(64'h15, 7'd5);
    pulse_flush();
    for (int n = 0; n < 20 && !found; n++) begin
      if (dut.state == PAD) found = 1;
      else tick();
    end
    n_cmp += 2;
    if (!found) begin n_bad++; $display("FAIL rst_flush_reach_pad: state %s want PAD", dut.state.name()); end
    if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_flush_pre_valid: got %b want 1", bus.out_valid); end
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    n_cmp += 5;
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_flush_out_valid: got %b want 0", bus.out_valid); end
    if (level !== 7'd0) begin n_bad++; $display("FAIL rst_flush_level: got %0d want 0", level); end
    if (bus.code_ready !== 1'b1) begin n_bad++; $display("FAIL rst_flush_code_ready: got %b want 1", bus.code_ready); end
    if (flush_done !== 1'b0) begin n_bad++; $display("FAIL rst_flush_done: got %b want 0", flush_done); end
    if (bit_count !== 32'd0) begin n_bad++; $display("FAIL rst_flush_bit_count: got %0d want 0", bit_count); end
    tick();
    rst = 1'b0;
    repeat (10) tick();
    n_cmp += 2;
    if (done_cnt != d0) begin n_bad++; $display("FAIL rst_flush_no_done: got %0d pulses want 0", done_cnt - d0); end
    if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_flush_stays_empty: got %b want 0", bus.out_valid); end
  endtask

  initial begin
    test_reset();
    test_pack();
    test_flush();
    test_back_pressure();
    test_len_edges();
    test_reset_mid_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
